// File: rtl/bus_arbiter_rr.sv
// Bus arbiter: master 0 has absolute priority, masters 1..N-1 share the bus round-robin.
// Optional grant-hold limit for masters 1..N-1 is enabled by defining BUS_ARB_HOLD_LIMIT_EN.
module bus_arbiter_rr #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_MASTERS-1:0]         req_i,
    output logic [N_MASTERS-1:0]         gnt_o,
    output logic [$clog2(N_MASTERS)-1:0] gnt_idx_o,
    output logic                         busy_o
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);
    localparam int unsigned CNT_W = 8;

    if (N_MASTERS < 2 || N_MASTERS > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("bus_arbiter_rr: N_MASTERS or MAX_HOLD outside legal range");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
`ifdef BUS_ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    logic [N_MASTERS-1:0] cand;
    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;
    int unsigned          rr_pos;

    // Candidates exclude the current holder so a forced handoff never re-picks it
    assign cand = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;

    // Winner: master 0 first, else first requester after the pointer, wrapping within 1..N-1
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        rr_pos    = 0;
        if (cand[0]) begin
            win_valid = 1'b1;
        end else begin
            for (int unsigned i = 1; i < N_MASTERS; i++) begin
                rr_pos = ((32'(ptr_q) - 32'd1 + i) % (N_MASTERS - 1)) + 1;
                if (!win_valid && cand[IDX_W'(rr_pos)]) begin
                    win_valid = 1'b1;
                    win_idx   = IDX_W'(rr_pos);
                end
            end
        end
    end

    always_comb begin
        logic rearb;
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
`ifdef BUS_ARB_HOLD_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        rearb   = 1'b0;

        case (state_q)
            IDLE: begin
                rearb = 1'b1;
            end
            GRANT: begin
                if (!req_i[idx_q]) begin
                    rearb = 1'b1;
                end
`ifdef BUS_ARB_HOLD_LIMIT_EN
                // Saturate at the limit while nobody else wants the bus
                else if (idx_q != '0) begin
                    if (cnt_q >= CNT_W'(MAX_HOLD)) begin
                        if (|cand) rearb = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
            default: begin
                rearb = 1'b1;
            end
        endcase

        if (rearb) begin
            if (win_valid) begin
                state_d = GRANT;
                gnt_d   = N_MASTERS'(1) << win_idx;
                idx_d   = win_idx;
                busy_d  = 1'b1;
                if (win_idx != '0) ptr_d = win_idx;
`ifdef BUS_ARB_HOLD_LIMIT_EN
                // The counter value equals the number of grant cycles already served
                cnt_d   = (win_idx != '0) ? CNT_W'(1) : '0;
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
                cnt_d   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= IDX_W'(N_MASTERS - 1);
`ifdef BUS_ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (3 masters): vector table plus multi-cycle sequences.
module tb_bus_arbiter_rr;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] req_i;
    logic [2:0] gnt_o;
    logic [1:0] gnt_idx_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic [1:0] idx;
        logic       busy;
    } vec_t;

    vec_t tv[$];

    bus_arbiter_rr #(.N_MASTERS(3), .MAX_HOLD(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] g, input logic [1:0] i, input logic b);
        chk({nm, ".gnt"}, 8'(gnt_o), 8'(g));
        chk({nm, ".idx"}, 8'(gnt_idx_o), 8'(i));
        chk({nm, ".busy"}, 8'(busy_o), 8'(b));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] g, input logic [1:0] i);
        vec_t v;
        v.req  = r;
        v.gnt  = g;
        v.idx  = i;
        v.busy = (g != 3'b000);
        tv.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 3'b000;
        #1;
        chk_all("reset", 3'b000, 2'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i  = 3'b000;

        // After reset the pointer makes master 1 the first round-robin choice
        add(3'b000, 3'b000, 2'd0);
        add(3'b110, 3'b010, 2'd1);
        add(3'b100, 3'b100, 2'd2);
        add(3'b100, 3'b100, 2'd2);
        add(3'b000, 3'b000, 2'd0);
        add(3'b111, 3'b001, 2'd0);
        for (int k = 0; k < 9; k++) add(3'b111, 3'b001, 2'd0);
        add(3'b110, 3'b010, 2'd1);
        add(3'b101, 3'b001, 2'd0);
        add(3'b100, 3'b100, 2'd2);
        add(3'b110, 3'b100, 2'd2);
        add(3'b010, 3'b010, 2'd1);
        add(3'b011, 3'b010, 2'd1);
        add(3'b001, 3'b001, 2'd0);
        add(3'b000, 3'b000, 2'd0);
        add(3'b111, 3'b001, 2'd0);
        add(3'b110, 3'b100, 2'd2);
        add(3'b010, 3'b010, 2'd1);
        add(3'b000, 3'b000, 2'd0);

        #2;
        chk_all("por", 3'b000, 2'd0, 1'b0);
        do_reset();

        foreach (tv[n]) begin
            req_i = tv[n].req;
            step();
            chk_all($sformatf("vec%0d", n), tv[n].gnt, tv[n].idx, tv[n].busy);
        end

        // No requests: stays idle
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            chk_all($sformatf("idle%0d", k), 3'b000, 2'd0, 1'b0);
        end

        // Masters 1 and 2 alternate with 4-cycle transfers
        do_reset();
        req_i = 3'b110;
        step();
        chk_all("alt_first", 3'b010, 2'd1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            int w;
            int o;
            w = (k % 2 == 0) ? 1 : 2;
            o = 3 - w;
            req_i = 3'b110;
            for (int c = 0; c < 3; c++) begin
                step();
                chk_all($sformatf("alt%0d_hold%0d", k, c), 3'(1 << w), 2'(w), 1'b1);
            end
            req_i = 3'(1 << o);
            step();
            chk_all($sformatf("alt%0d_swap", k), 3'(1 << o), 2'(o), 1'b1);
        end

        // Asynchronous reset mid-grant, then fresh arbitration
        do_reset();
        req_i = 3'b010;
        step();
        chk_all("pre_rst", 3'b010, 2'd1, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all("async_rst", 3'b000, 2'd0, 1'b0);
        req_i = 3'b100;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_all("rst_rel", 3'b000, 2'd0, 1'b0);
        step();
        chk_all("post_rst", 3'b100, 2'd2, 1'b1);

`ifdef BUS_ARB_HOLD_LIMIT_EN
        // Master 1 loses the bus after exactly 4 grant cycles while master 2 waits
        do_reset();
        req_i = 3'b110;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_all($sformatf("hold_m1_%0d", c), 3'b010, 2'd1, 1'b1);
        end
        step();
        chk_all("hold_cut", 3'b100, 2'd2, 1'b1);

        // Master 0 is exempt from the hold limit
        do_reset();
        req_i = 3'b111;
        for (int c = 0; c < 8; c++) begin
            step();
            chk_all($sformatf("hold_m0_%0d", c), 3'b001, 2'd0, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL provide parameter N_MASTERS, default 3: number of requesting masters, legal range 2..8.
REQ-002 SHALL provide parameter MAX_HOLD, default 16: grant-hold limit in cycles, legal range 2..255; used only when BUS_ARB_HOLD_LIMIT_EN is defined.
REQ-003 SHALL provide port clk_i, input, 1 bit: clock, all state on the rising edge.
REQ-004 SHALL provide port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port req_i, input, N_MASTERS bits: per-master bus request, level-held for the whole transfer.
REQ-006 SHALL provide port gnt_o, output, N_MASTERS bits: registered one-hot grant, all-zero when the arbiter is idle.
REQ-007 SHALL provide port gnt_idx_o, output, $clog2(N_MASTERS) bits: index of the granted master, 0 when idle.
REQ-008 SHALL provide port busy_o, output, 1 bit: high whenever any grant is active.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt_o bit high).
REQ-010 SHALL issue grants with one-cycle latency: a request sampled in IDLE at edge t drives gnt_o from edge t+1.
REQ-011 SHALL give master 0 (the lock master) absolute priority on every arbitration decision.
REQ-012 SHALL never preempt master 0 once granted; it holds until req_i[0] deasserts.
REQ-013 SHALL arbitrate masters 1..N_MASTERS-1 round-robin: the search starts at last_granted+1, wraps from N_MASTERS-1 to 1, and skips 0.
REQ-014 SHALL update the round-robin pointer only when a master 1..N_MASTERS-1 receives a new grant.
REQ-015 SHALL keep the grant while the granted master's req_i stays high; other requests wait (unless REQ-024 applies).
REQ-016 SHALL re-arbitrate on the edge after the granted master drops its request: if any other request is pending, the new winner is granted directly with no idle bubble; otherwise the FSM returns to IDLE.
REQ-017 SHALL give master 0 the bus at the next re-arbitration point when it requests during another master's grant; it SHALL NOT preempt that grant (except via REQ-024).
REQ-018 SHALL evaluate simultaneous requests in the same cycle strictly by REQ-011 and REQ-013.
REQ-019 SHALL keep gnt_o one-hot or zero in every cycle.
REQ-020 SHALL keep gnt_idx_o and busy_o consistent with gnt_o in the same cycle.

Reset
REQ-021 SHALL, on rst_ni low, asynchronously force: FSM to IDLE, gnt_o=0, gnt_idx_o=0, busy_o=0, round-robin pointer so that master 1 is next, hold counter=0.
REQ-022 SHALL, on reset asserted mid-grant, drop the grant immediately without waiting for a clock edge.
REQ-023 SHALL, on reset release, arbitrate afresh from IDLE on the first clock edge.

Configuration
REQ-024 SHALL, with BUS_ARB_HOLD_LIMIT_EN defined, count consecutive grant cycles of a master 1..N_MASTERS-1 in an 8-bit counter; once the count reaches MAX_HOLD while another master is requesting, the next edge SHALL hand the grant to the next winner per REQ-011/REQ-013, reset the counter and advance the pointer.
REQ-025 SHALL exempt master 0 from the hold limit.
REQ-026 SHALL hold the counter at MAX_HOLD, without wrapping, when no other master is requesting.
REQ-027 SHALL, with BUS_ARB_HOLD_LIMIT_EN undefined, compile out the counter and grant without time limit.

Verification
REQ-028 SHALL cover: reset, then req_i=3'b110 at edge 0 -> gnt_o=3'b010 from edge 1; drop req_i[1] -> gnt_o=3'b100 on the next edge with no idle cycle.
REQ-029 SHALL cover: req_i=3'b111 from IDLE -> gnt_o=3'b001; keep req_i[0] high for 10 cycles -> gnt_o stays 3'b001; drop it -> gnt_o=3'b010.
REQ-030 SHALL cover: masters 1 and 2 both requesting continuously, each dropping for one cycle after a 4-cycle transfer -> grants alternate 1,2,1,2 and gnt_idx_o tracks them.
REQ-031 SHALL cover, with BUS_ARB_HOLD_LIMIT_EN and MAX_HOLD=4: master 1 held and master 2 requesting -> master 1 loses the grant after exactly 4 grant cycles and gnt_o=3'b100.
REQ-032 SHALL cover: rst_ni pulsed low mid-grant -> gnt_o=0 and busy_o=0 asynchronously; after release with req_i=3'b100 -> gnt_o=3'b100 one edge later.
REQ-033 SHALL cover: req_i=0 throughout -> FSM stays IDLE, gnt_o=0, busy_o=0 for 20 cycles.
